instr_fetch_unit: RTL and testbench

- Instruction-fetch stage of the sequential CPU.
- Sits directly upstream of the decode stage and drives the shared `mem` block's read side (address, read, write; memIn is don't-care).
- Holds the PC and reads one word per cycle from `mem`. Buffers fetched {pc, instruction} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump) and traps misaligned targets.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 83 ++++++++
 tb/tb_instr_fetch_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: architectural widths, reset entry point, fetch
// state encoding and the {pc, inst} entry carried through the fetch buffer.
package cpu_pkg;

    localparam int          XLEN       = 32;
    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] RESET_PC   = 32'h0000_0028;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of fetched {pc, inst} entries with a synchronous
// flush; the head is presented combinationally from storage.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output fetch_entry_t     head_o
);

    fetch_entry_t     slot_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero until first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
        end else if (push_i && !flush_i) begin
            slot_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = slot_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads one word per cycle while the buffer
// has room, and traps redirects to non-word-aligned targets.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] START_ADDR = RESET_PC,
    parameter int          DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        misalign
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    logic             pop, space, push, flush;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flush    = 1'b0;
        push     = 1'b0;
        mem_read = 1'b0;
        pop      = (state_q == RUN) && (count != '0) && inst_ready;
        space    = (count < CNT_W'(DEPTH)) || pop;
        if (state_q == RUN) begin
            if (redirect) begin
                // Flush outranks any same-cycle pop; a bad target parks the
                // unit in FAULT with the PC left where it was.
                flush = 1'b1;
                if (redirect_pc[1:0] == 2'b00) pc_d    = redirect_pc;
                else                           state_d = FAULT;
            end else begin
                mem_read = rst_n && space;
                push     = mem_read;
                if (push) pc_d = pc_q + 32'(WORD_BYTES);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= START_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i ('{pc: pc_q, inst: mem_rdata}),
        .pop_i       (pop),
        .count_o     (count),
        .head_o      (head)
    );

    assign mem_addr   = pc_q;
    assign mem_write  = 1'b0;
    assign inst_valid = (state_q == RUN) && (count != '0);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;
    assign misalign   = (state_q == FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table plus
// hand-written sequences for fill/stream and asynchronous reset.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misalign;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    instr_fetch_unit #(.START_ADDR(32'h0000_0028), .DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_addr    (mem_addr),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .misalign    (misalign)
    );

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[%0d] got %h expected %h", name, idx, got, exp);
    endtask

    typedef struct packed {
        logic        rst;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        v;
        logic [31:0] ipc;
        logic        rd_e;
        logic [31:0] addr;
        logic        mis;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    initial begin
        // rst  rd   rpc            rdy   v    ipc            read  addr           mis
        tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h28,        1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h28,        1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h28,        1'b1, 32'h2C,        1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h28,        1'b0, 32'h30,        1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h28,        1'b0, 32'h30,        1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h28,        1'b0, 32'h30,        1'b0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h28,        1'b1, 32'h30,        1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h2C,        1'b1, 32'h34,        1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h30,        1'b0, 32'h38,        1'b0};
        tbl[9]  = '{1'b1, 1'b1, 32'h40,        1'b1, 1'b1, 32'h30,        1'b0, 32'h38,        1'b0};
        tbl[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h40,        1'b0};
        tbl[11] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h40,        1'b1, 32'h44,        1'b0};
        tbl[12] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h44,        1'b1, 32'h48,        1'b0};
        tbl[13] = '{1'b1, 1'b1, 32'h42,        1'b1, 1'b1, 32'h48,        1'b0, 32'h4C,        1'b0};
        tbl[14] = '{1'b1, 1'b1, 32'h40,        1'b1, 1'b0, 32'h0,         1'b0, 32'h4C,        1'b1};
        tbl[15] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h4C,        1'b1};
        tbl[16] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h28,        1'b0};
        tbl[17] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h28,        1'b0};
        tbl[18] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h28,        1'b0, 32'h2C,        1'b0};
        tbl[19] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0,         1'b0};
        tbl[21] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 32'h4,         1'b0};

        // Backpressure, redirect-while-full, misaligned trap, PC wrap.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst_n       = tbl[i].rst;
            redirect    = tbl[i].rd;
            redirect_pc = tbl[i].rpc;
            inst_ready  = tbl[i].rdy;
            #1;
            check("inst_valid", i, 32'(inst_valid), 32'(tbl[i].v));
            check("mem_read",   i, 32'(mem_read),   32'(tbl[i].rd_e));
            check("mem_addr",   i, mem_addr,        tbl[i].addr);
            check("misalign",   i, 32'(misalign),   32'(tbl[i].mis));
            check("mem_write",  i, 32'(mem_write),  32'h0);
            if (tbl[i].v) begin
                check("inst_pc", i, inst_pc, tbl[i].ipc);
                check("inst",    i, inst,    mem_word(tbl[i].ipc));
            end
            if (!tbl[i].rst) begin
                check("rst_inst",    i, inst,    32'h0);
                check("rst_inst_pc", i, inst_pc, 32'h0);
            end
        end

        // Streaming from reset with decode always ready: 0x28..0x50 back to back.
        @(negedge clk);
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("stream_fill_valid", 0, 32'(inst_valid), 32'h0);
        check("stream_fill_read",  0, 32'(mem_read),   32'h1);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            #1;
            check("stream_valid",   k, 32'(inst_valid), 32'h1);
            check("stream_inst_pc", k, inst_pc, 32'h28 + 32'(4 * k));
            check("stream_inst",    k, inst,    mem_word(32'h28 + 32'(4 * k)));
        end

        // Asynchronous reset between edges with two entries buffered.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; inst_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("async_pre_valid",   0, 32'(inst_valid), 32'h1);
        check("async_pre_read",    0, 32'(mem_read),   32'h0);
        #1 rst_n = 1'b0;
        #1;
        check("async_valid",   0, 32'(inst_valid), 32'h0);
        check("async_read",    0, 32'(mem_read),   32'h0);
        check("async_inst_pc", 0, inst_pc,         32'h0);
        check("async_addr",    0, mem_addr,        32'h28);
        @(negedge clk);
        rst_n = 1'b1; inst_ready = 1'b1;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                #1;
                if (inst_valid) begin
                    seen = 1'b1;
                    check("async_first_pc", c, inst_pc, 32'h28);
                end else begin
                    @(negedge clk);
                end
            end
            if (!seen) check("async_first_timeout", 0, 32'h0, 32'h1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
